// File: rtl/oam_dma_arbiter_if.sv
// CPU-side and memory-side bus bundle for the OAM DMA arbiter.
// slave: arbiter view (cpu_* in, mem_* out); master: the opposite side.
interface oam_dma_arbiter_if;
  logic [15:0] cpu_address;
  logic [7:0]  cpu_o_data;
  logic        cpu_wren;
  logic        cpu_read;
  logic        cpu_ce;
  logic [15:0] mem_address;
  logic [7:0]  mem_o_data;
  logic        mem_wren;
  logic        mem_read;
  logic [7:0]  mem_i_data;
  logic        dma_busy;

  modport slave (
    input  cpu_address, cpu_o_data, cpu_wren, cpu_read,
    input  mem_i_data,
    output cpu_ce, dma_busy,
    output mem_address, mem_o_data, mem_wren, mem_read
  );

  modport master (
    output cpu_address, cpu_o_data, cpu_wren, cpu_read,
    output mem_i_data,
    input  cpu_ce, dma_busy,
    input  mem_address, mem_o_data, mem_wren, mem_read
  );
endinterface

// File: rtl/oam_dma_arbiter.sv
// OAM DMA arbiter: a CPU write to DMA_REG stalls the CPU and copies
// LENGTH bytes of page {page,00..} to DEST_ADDR. Ports: clock, reset_n, bus.
module oam_dma_arbiter #(
  parameter logic [15:0] DMA_REG   = 16'h4014,
  parameter logic [15:0] DEST_ADDR = 16'h2004,
  parameter int          LENGTH    = 256
) (
  input  logic              clock,
  input  logic              reset_n,
  oam_dma_arbiter_if.slave  bus
);

  localparam logic [8:0] LAST = 9'(LENGTH - 1);

  typedef enum logic [2:0] {
    IDLE, DUMMY, ALIGN, RD, WR
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] page_q, page_d;
  logic [8:0] index_q, index_d;
  logic       parity_q;

  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    index_d = index_q;
    unique case (state_q)
      IDLE: begin
        if (bus.cpu_wren && bus.cpu_address == DMA_REG) begin
          state_d = DUMMY;
          page_d  = bus.cpu_o_data;
          index_d = '0;
        end
      end
      // An odd-phase DUMMY inserts ALIGN so reads start on a fixed phase.
      DUMMY: state_d = parity_q ? ALIGN : RD;
      ALIGN: state_d = RD;
      RD:    state_d = WR;
      WR: begin
        if (index_q == LAST) begin
          state_d = IDLE;
        end else begin
          index_d = index_q + 9'd1;
          state_d = RD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      page_q   <= '0;
      index_q  <= '0;
      parity_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      page_q   <= page_d;
      index_q  <= index_d;
      parity_q <= ~parity_q;
    end
  end

  always_comb begin
    bus.cpu_ce      = 1'b0;
    bus.dma_busy    = 1'b1;
    bus.mem_address = DEST_ADDR;
    bus.mem_o_data  = 8'h00;
    bus.mem_wren    = 1'b0;
    bus.mem_read    = 1'b0;
    unique case (state_q)
      IDLE: begin
        bus.cpu_ce      = 1'b1;
        bus.dma_busy    = 1'b0;
        bus.mem_address = bus.cpu_address;
        bus.mem_o_data  = bus.cpu_o_data;
        bus.mem_wren    = bus.cpu_wren;
        bus.mem_read    = bus.cpu_read;
      end
      RD: begin
        bus.mem_address = {page_q, index_q[7:0]};
        bus.mem_read    = 1'b1;
      end
      WR: begin
        bus.mem_o_data = bus.mem_i_data;
        bus.mem_wren   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Scoreboard bench for oam_dma_arbiter (LENGTH 256 and LENGTH 4 copies).
// Stimulus pushes expected reads/writes/stalls; a negedge monitor checks.
module tb_oam_dma_arbiter;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  oam_dma_arbiter_if bus0 ();
  oam_dma_arbiter_if bus4 ();

  oam_dma_arbiter dut0 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus0)
  );

  oam_dma_arbiter #(.LENGTH(4)) dut4 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus4)
  );

  logic [7:0] mem [65536];

  always @(posedge clock) begin
    bus0.mem_i_data <= mem[bus0.mem_address];
    bus4.mem_i_data <= mem[bus4.mem_address];
  end

  logic tb_par;
  always @(posedge clock or negedge reset_n)
    if (!reset_n) tb_par <= 1'b0;
    else tb_par <= ~tb_par;

  logic        ce   [2];
  logic        busy [2];
  logic        rd   [2];
  logic        wr   [2];
  logic [15:0] ma   [2];
  logic [7:0]  md   [2];

  always_comb begin
    ce[0] = bus0.cpu_ce;      ce[1] = bus4.cpu_ce;
    busy[0] = bus0.dma_busy;  busy[1] = bus4.dma_busy;
    rd[0] = bus0.mem_read;    rd[1] = bus4.mem_read;
    wr[0] = bus0.mem_wren;    wr[1] = bus4.mem_wren;
    ma[0] = bus0.mem_address; ma[1] = bus4.mem_address;
    md[0] = bus0.mem_o_data;  md[1] = bus4.mem_o_data;
  end

  logic [15:0] rdq [2][$];
  logic [7:0]  wrq [2][$];
  int          stq [2][$];
  int          run [2];
  int          wcnt [2];
  bit          abort_f [2];

  int checks = 0;
  int errors = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  initial begin
    for (int g = 0; g < 2; g++) begin
      run[g] = 0;
      wcnt[g] = 0;
      abort_f[g] = 1'b0;
    end
  end

  always @(negedge clock) begin
    for (int g = 0; g < 2; g++) begin
      if (busy[g] && rd[g]) begin
        if (rdq[g].size() == 0) chk("unexpected_read", {16'h0, ma[g]}, 32'hffff_ffff);
        else chk("rd_addr", {16'h0, ma[g]}, {16'h0, rdq[g].pop_front()});
      end
      if (busy[g] && wr[g]) begin
        wcnt[g]++;
        chk("wr_addr", {16'h0, ma[g]}, 32'h2004);
        if (wrq[g].size() == 0) chk("unexpected_write", {24'h0, md[g]}, 32'hffff_ffff);
        else chk("wr_data", {24'h0, md[g]}, {24'h0, wrq[g].pop_front()});
      end
      if (busy[g] && !rd[g] && !wr[g])
        chk("idle_bus", {8'h0, ma[g], md[g]}, {8'h0, 16'h2004, 8'h00});
      if (!ce[g]) begin
        run[g]++;
      end else if (run[g] > 0) begin
        if (abort_f[g]) abort_f[g] = 1'b0;
        else if (stq[g].size() == 0) chk("unexpected_stall", run[g], 0);
        else chk("stall_len", run[g], stq[g].pop_front());
        run[g] = 0;
      end
    end
  end

  task automatic drive(int g, logic [15:0] a, logic [7:0] d, logic w, logic r);
    if (g == 0) begin
      bus0.cpu_address = a; bus0.cpu_o_data = d;
      bus0.cpu_wren = w; bus0.cpu_read = r;
    end else begin
      bus4.cpu_address = a; bus4.cpu_o_data = d;
      bus4.cpu_wren = w; bus4.cpu_read = r;
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // want: -1 no parity constraint, else required parity in trigger cycle
  task automatic trig(int g, logic [7:0] pg, int want, int len,
                      int nrd, int nwr, bit ab);
    logic [15:0] a;
    while (want >= 0 && tb_par != want[0]) step();
    for (int i = 0; i < nrd; i++) begin
      a = {pg, 8'(i)};
      rdq[g].push_back(a);
    end
    for (int i = 0; i < nwr; i++) begin
      a = {pg, 8'(i)};
      wrq[g].push_back(mem[a]);
    end
    if (!ab) stq[g].push_back(1 + (tb_par ? 0 : 1) + 2 * len);
    drive(g, 16'h4014, pg, 1'b1, 1'b0);
    step();
    drive(g, 16'h0000, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic wait_idle(int g, int budget);
    int n = 0;
    while (!ce[g] && n < budget) begin
      step();
      n++;
    end
    chk("idle_timeout", {31'h0, ce[g]}, 32'h1);
  endtask

  initial begin
    int n;
    int base;
    for (int i = 0; i < 65536; i++) begin
      logic [15:0] a;
      a = 16'(i);
      mem[i] = a[7:0] ^ {a[14:8], a[15]} ^ 8'h5a;
    end
    mem[16'hff00] = 8'h11;
    mem[16'hff01] = 8'h22;
    mem[16'hff02] = 8'h33;
    mem[16'hff03] = 8'h44;
    drive(0, 16'h0, 8'h0, 1'b0, 1'b0);
    drive(1, 16'h0, 8'h0, 1'b0, 1'b0);

    #2;
    chk("rst_ce0", {31'h0, bus0.cpu_ce}, 1);
    chk("rst_busy0", {31'h0, bus0.dma_busy}, 0);
    chk("rst_ce4", {31'h0, bus4.cpu_ce}, 1);
    chk("rst_busy4", {31'h0, bus4.dma_busy}, 0);
    @(negedge clock);
    reset_n = 1'b1;
    step();

    drive(0, 16'h1234, 8'h00, 1'b0, 1'b1);
    #1;
    chk("pt_rd_addr", {16'h0, bus0.mem_address}, 32'h1234);
    chk("pt_rd_strobes", {30'h0, bus0.mem_read, bus0.mem_wren}, 32'h2);
    chk("pt_rd_busy", {31'h0, bus0.dma_busy}, 0);
    step();
    drive(0, 16'h0300, 8'ha5, 1'b1, 1'b0);
    #1;
    chk("pt_wr_addr", {16'h0, bus0.mem_address}, 32'h0300);
    chk("pt_wr_data", {24'h0, bus0.mem_o_data}, 32'ha5);
    chk("pt_wr_strobes", {30'h0, bus0.mem_read, bus0.mem_wren}, 32'h1);
    step();
    drive(0, 16'h0, 8'h0, 1'b0, 1'b0);

    trig(0, 8'h02, 1, 256, 256, 256, 1'b0);
    step(); step(); step();
    drive(0, 16'h4014, 8'h33, 1'b1, 1'b1);
    chk("busy_ce", {31'h0, bus0.cpu_ce}, 0);
    step();
    drive(0, 16'h0, 8'h0, 1'b0, 1'b0);
    wait_idle(0, 600);

    trig(0, 8'h02, 0, 256, 256, 256, 1'b0);
    wait_idle(0, 600);

    trig(1, 8'hff, -1, 4, 4, 4, 1'b0);
    wait_idle(1, 20);
    trig(1, 8'h10, -1, 4, 4, 4, 1'b0);
    wait_idle(1, 20);

    base = wcnt[0];
    trig(0, 8'h05, -1, 256, 11, 10, 1'b1);
    n = 0;
    while (wcnt[0] != base + 10 && n < 100) begin
      @(negedge clock);
      #1;
      n++;
    end
    chk("abort_reach", wcnt[0], base + 10);
    @(posedge clock);
    @(posedge clock);
    #1;
    abort_f[0] = 1'b1;
    reset_n = 1'b0;
    #1;
    chk("abort_wren", {31'h0, bus0.mem_wren}, 0);
    chk("abort_ce", {31'h0, bus0.cpu_ce}, 1);
    chk("abort_busy", {31'h0, bus0.dma_busy}, 0);
    step();
    reset_n = 1'b1;
    step();

    trig(0, 8'h07, -1, 256, 256, 256, 1'b0);
    wait_idle(0, 600);

    step(); step();
    for (int g = 0; g < 2; g++) begin
      chk("rdq_empty", rdq[g].size(), 0);
      chk("wrq_empty", wrq[g].size(), 0);
      chk("stq_empty", stq[g].size(), 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
